// File: rtl/spi_mem_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
// Shared definitions for the SPI SRAM controller: serial opcodes, default
// field widths, the total frame length and the controller state encoding.
// -----------------------------------------------------------------------------
package spi_mem_pkg;

   localparam int          CMD_W      = 8;
   localparam int          ADDR_W_DEF = 24;
   localparam int          DATA_W_DEF = 16;

   localparam logic [7:0]  CMD_READ   = 8'h03;
   localparam logic [7:0]  CMD_WRITE  = 8'h02;

   // One transaction on the wire: opcode, address, data word.
   localparam int          FRAME_W    = CMD_W + ADDR_W_DEF + DATA_W_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Frame length for non-default address/data widths.
   function automatic int frame_bits(input int addr_w, input int data_w);
      return CMD_W + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_shifter.sv
// -----------------------------------------------------------------------------
// spi_shifter
// Serialises one command/address/data frame MSB first in SPI mode 0 at
// clk/2 and captures the returned data word from MISO.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   load          start a frame (frame_in sampled on this edge)
//   frame_in      frame to transmit, bit FRAME_BITS-1 goes out first
//   spi_miso      serial data from the memory
//   spi_clk       registered serial clock, idles low
//   spi_mosi      registered serial data to the memory
//   last          high during the final half-bit of the frame
//   rdata         last DATA_BITS bits sampled from MISO
// -----------------------------------------------------------------------------
module spi_shifter
   import spi_mem_pkg::*;
#(
   parameter int FRAME_BITS = FRAME_W,
   parameter int DATA_BITS  = DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [FRAME_BITS-1:0] frame_in,
   input  logic                  spi_miso,
   output logic                  spi_clk,
   output logic                  spi_mosi,
   output logic                  last,
   output logic [DATA_BITS-1:0]  rdata
);

   localparam int CNT_W = $clog2(FRAME_BITS);

   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  phase_q, phase_d;
   logic                  active_q, active_d;
   logic [DATA_BITS-1:0]  cap_q, cap_d;
   logic                  spi_clk_q, spi_clk_d;
   logic                  spi_mosi_q, spi_mosi_d;

   always_comb begin
      frame_d    = frame_q;
      bit_cnt_d  = bit_cnt_q;
      phase_d    = phase_q;
      active_d   = active_q;
      cap_d      = cap_q;
      spi_clk_d  = spi_clk_q;
      spi_mosi_d = spi_mosi_q;

      if (load) begin
         frame_d    = frame_in;
         bit_cnt_d  = CNT_W'(FRAME_BITS - 1);
         phase_d    = 1'b0;
         active_d   = 1'b1;
         spi_clk_d  = 1'b0;
         spi_mosi_d = frame_in[FRAME_BITS-1];
      end else if (active_q) begin
         if (!phase_q) begin
            // This edge raises spi_clk; the memory's bit is stable now.
            phase_d   = 1'b1;
            spi_clk_d = 1'b1;
            if (bit_cnt_q < CNT_W'(DATA_BITS))
               cap_d = {cap_q[DATA_BITS-2:0], spi_miso};
         end else begin
            phase_d   = 1'b0;
            spi_clk_d = 1'b0;
            if (bit_cnt_q == '0) begin
               active_d   = 1'b0;
               spi_mosi_d = 1'b0;
            end else begin
               bit_cnt_d  = bit_cnt_q - 1'b1;
               // Rotate rather than shift so every frame bit has a reader;
               // the wrapped bit is never transmitted.
               frame_d    = {frame_q[FRAME_BITS-2:0], frame_q[FRAME_BITS-1]};
               spi_mosi_d = frame_q[FRAME_BITS-2];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q    <= '0;
         bit_cnt_q  <= '0;
         phase_q    <= 1'b0;
         active_q   <= 1'b0;
         cap_q      <= '0;
         spi_clk_q  <= 1'b0;
         spi_mosi_q <= 1'b0;
      end else begin
         frame_q    <= frame_d;
         bit_cnt_q  <= bit_cnt_d;
         phase_q    <= phase_d;
         active_q   <= active_d;
         cap_q      <= cap_d;
         spi_clk_q  <= spi_clk_d;
         spi_mosi_q <= spi_mosi_d;
      end
   end

   assign spi_clk  = spi_clk_q;
   assign spi_mosi = spi_mosi_q;
   assign last     = active_q & phase_q & (bit_cnt_q == '0);
   assign rdata    = cap_q;

endmodule

// File: rtl/spi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// spi_mem_ctrl
// SPI master turning single-word CPU requests into SPI SRAM read/write
// transactions (opcode + address + data, mode 0, MSB first, clk/2).
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   req_valid     CPU request present
//   req_ready     controller idle and able to accept (registered)
//   req_write     1 = write, 0 = read
//   req_addr      byte address sent as-is on the wire
//   req_wdata     write data, big-endian (byte at addr = [15:8])
//   rsp_valid     one-cycle completion pulse for reads and writes
//   rsp_rdata     read data; updated only when a read completes
//   spi_select    chip select, active low
//   spi_clk       serial clock, idles low
//   spi_mosi      serial data out
//   spi_miso      serial data in
// -----------------------------------------------------------------------------
module spi_mem_ctrl #(
   parameter int         ADDR_W    = spi_mem_pkg::ADDR_W_DEF,
   parameter int         DATA_W    = spi_mem_pkg::DATA_W_DEF,
   parameter logic [7:0] CMD_READ  = spi_mem_pkg::CMD_READ,
   parameter logic [7:0] CMD_WRITE = spi_mem_pkg::CMD_WRITE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              spi_select,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int FW = spi_mem_pkg::frame_bits(ADDR_W, DATA_W);

   spi_mem_pkg::state_e state_q, state_d;

   logic              write_q, write_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              spi_select_q, spi_select_d;

   logic              handshake;
   logic [FW-1:0]     frame;
   logic              shift_last;
   logic [DATA_W-1:0] shift_rdata;

   // req_ready_q is only ever set while in IDLE, so it qualifies the handshake.
   assign handshake = req_valid & req_ready_q;

   // Reads send zeros in the data slot.
   assign frame = {(req_write ? CMD_WRITE : CMD_READ),
                   req_addr,
                   (req_write ? req_wdata : {DATA_W{1'b0}})};

   spi_shifter #(
      .FRAME_BITS (FW),
      .DATA_BITS  (DATA_W)
   ) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .load     (handshake),
      .frame_in (frame),
      .spi_miso (spi_miso),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .last     (shift_last),
      .rdata    (shift_rdata)
   );

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = rsp_rdata_q;
      spi_select_d = spi_select_q;

      case (state_q)
         spi_mem_pkg::IDLE: begin
            spi_select_d = 1'b1;
            if (handshake) begin
               state_d      = spi_mem_pkg::SHIFT;
               write_d      = req_write;
               spi_select_d = 1'b0;
            end
         end
         spi_mem_pkg::SHIFT: begin
            if (shift_last) begin
               // The final MISO bit was captured one edge earlier, so the
               // shifter's word is complete here.
               state_d      = spi_mem_pkg::DONE;
               spi_select_d = 1'b1;
               rsp_valid_d  = 1'b1;
               if (!write_q)
                  rsp_rdata_d = shift_rdata;
            end
         end
         spi_mem_pkg::DONE: begin
            state_d      = spi_mem_pkg::IDLE;
            spi_select_d = 1'b1;
         end
         default: begin
            state_d      = spi_mem_pkg::IDLE;
            spi_select_d = 1'b1;
         end
      endcase

      req_ready_d = (state_d == spi_mem_pkg::IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= spi_mem_pkg::IDLE;
         write_q      <= 1'b0;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         spi_select_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         spi_select_q <= spi_select_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign spi_select = spi_select_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_ctrl
// Bench for spi_mem_ctrl: an SPI SRAM device model on the serial pins, a
// reference memory predicting read data, a scoreboard for responses and
// decoded frames, and a protocol monitor on the SPI pins.
// -----------------------------------------------------------------------------
module tb_spi_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [23:0] req_addr  = '0;
   logic [15:0] req_wdata = '0;
   logic        spi_miso  = 1'b0;
   logic        req_ready, rsp_valid, spi_select, spi_clk, spi_mosi;
   logic [15:0] rsp_rdata;

   spi_mem_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .spi_select (spi_select),
      .spi_clk    (spi_clk),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, what);
   endtask

   // ---------------- memories: device (on the wire) and reference ----------
   logic [7:0] dev_mem [logic [23:0]];
   logic [7:0] ref_mem [logic [23:0]];

   function automatic logic [7:0] dev_rd(input logic [23:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : 8'h00;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [23:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   // ---------------- scoreboard queues ----------------
   logic [15:0] exp_q    [$];   // expected rsp_rdata at each rsp_valid
   logic [47:0] exp_fr_q [$];   // expected frame seen on MOSI
   int          hs_q     [$];   // handshake edges awaiting a response
   int          hs_log   [$];
   int          rsp_log  [$];
   logic [15:0] last_rd = '0;

   // ---------------- SPI SRAM device model (mode 0) ----------------
   logic [47:0] s_sr = '0;
   logic [15:0] s_tx = '0;
   int          s_cnt = 0;

   always @(negedge spi_select) s_cnt = 0;

   always @(posedge spi_clk) begin
      if (spi_select === 1'b0) begin
         s_sr = {s_sr[46:0], spi_mosi};
         s_cnt++;
         if (s_cnt == 32 && s_sr[31:24] == 8'h03)
            s_tx = {dev_rd(s_sr[23:0]), dev_rd(s_sr[23:0] + 24'd1)};
         if (s_cnt == 48) begin
            if (exp_fr_q.size() == 0) fail_now("frame", "frame received with none expected");
            else chk("frame", s_sr, exp_fr_q.pop_front());
            if (s_sr[47:40] == 8'h02) begin
               dev_mem[s_sr[39:16]]          = s_sr[15:8];
               dev_mem[s_sr[39:16] + 24'd1]  = s_sr[7:0];
            end
         end
      end
   end

   always @(negedge spi_clk) begin
      if (spi_select === 1'b0 && s_cnt >= 32 && s_cnt < 48)
         spi_miso = s_tx[47 - s_cnt];
   end

   // ---------------- response monitor ----------------
   always @(negedge clk) begin
      if (!rst && req_valid && req_ready) begin
         hs_q.push_back(cyc + 1);
         hs_log.push_back(cyc + 1);
      end
      if (rsp_valid) begin
         if (exp_q.size() == 0) fail_now("rsp_unexpected", "rsp_valid with nothing outstanding");
         else begin
            chk("rdata", 48'(rsp_rdata), 48'(exp_q.pop_front()));
            if (hs_q.size() > 0) chk_int("latency", cyc - hs_q.pop_front(), 96);
            else fail_now("latency", "response without a recorded handshake");
            rsp_log.push_back(cyc);
         end
      end
   end

   // ---------------- SPI protocol monitor ----------------
   logic p_sel = 1'b1, p_clk = 1'b0, p_mosi = 1'b0;
   int   rises = 0, hi_cnt = 0, last_gap = 0;
   bit   win_rst = 1'b0;

   always @(negedge clk) begin
      if (spi_clk !== p_clk && p_sel !== 1'b0)
         fail_now("proto_clk", "spi_clk toggled while deselected");
      if (spi_mosi !== p_mosi && spi_clk !== 1'b0)
         fail_now("proto_mosi", "spi_mosi changed while spi_clk high");
      if (p_sel === 1'b1 && spi_select === 1'b0) begin
         last_gap = hi_cnt;
         hi_cnt   = 0;
         rises    = 0;
         win_rst  = 1'b0;
      end
      if (p_clk === 1'b0 && spi_clk === 1'b1) rises++;
      if (spi_select === 1'b1) hi_cnt++;
      if (rst) win_rst = 1'b1;
      if (p_sel === 1'b0 && spi_select === 1'b1 && !win_rst)
         chk_int("rises_per_window", rises, 48);
      p_sel  = spi_select;
      p_clk  = spi_clk;
      p_mosi = spi_mosi;
   end

   // ---------------- stimulus ----------------
   // Called and returns just after a rising edge.
   task automatic issue(input bit w, input logic [23:0] a, input logic [15:0] d, input bit hold);
      int n;
      logic [15:0] r;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      n = 0;
      while (!req_ready && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 400) begin
         fail_now("handshake_timeout", "req_ready never rose");
         req_valid = 1'b0;
         return;
      end
      if (w) begin
         exp_fr_q.push_back({8'h02, a, d});
         exp_q.push_back(last_rd);
         ref_mem[a]         = d[15:8];
         ref_mem[a + 24'd1] = d[7:0];
      end else begin
         r = {ref_rd(a), ref_rd(a + 24'd1)};
         exp_fr_q.push_back({8'h03, a, 16'h0000});
         exp_q.push_back(r);
         last_rd = r;
      end
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp_q.size() != 0 || exp_fr_q.size() != 0) && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (n >= 500) begin
         fail_now("done_timeout", "transaction did not complete");
         exp_q.delete();
         exp_fr_q.delete();
         hs_q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int h0, r0;
      bit w;
      logic [23:0] a;
      logic [15:0] d;

      dev_mem[24'h001234] = 8'hBE; dev_mem[24'h001235] = 8'hEF;
      dev_mem[24'h000000] = 8'h12; dev_mem[24'h000001] = 8'h34;
      dev_mem[24'hFFFFFE] = 8'h5A; dev_mem[24'hFFFFFF] = 8'hC3;
      ref_mem = dev_mem;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_select", 48'(spi_select), 48'(1));
      chk("rst_sclk",   48'(spi_clk),    48'(0));
      chk("rst_mosi",   48'(spi_mosi),   48'(0));
      chk("rst_rspv",   48'(rsp_valid),  48'(0));
      chk("rst_rdata",  48'(rsp_rdata),  48'(0));
      chk("rst_ready",  48'(req_ready),  48'(0));
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_reset", 48'(req_ready), 48'(1));

      // directed read
      issue(1'b0, 24'h001234, 16'h0000, 1'b0);
      wait_done();
      chk("read_beef", 48'(rsp_rdata), 48'(16'hBEEF));

      // directed write
      issue(1'b1, 24'h00ABCD, 16'hA55A, 1'b0);
      wait_done();
      chk("dbg_hi", 48'(dev_rd(24'h00ABCD)), 48'(8'hA5));
      chk("dbg_lo", 48'(dev_rd(24'h00ABCE)), 48'(8'h5A));
      chk("rdata_hold", 48'(rsp_rdata), 48'(16'hBEEF));

      // back-to-back with req_valid held high
      h0 = hs_log.size();
      r0 = rsp_log.size();
      issue(1'b1, 24'h000010, 16'h1111, 1'b1);
      issue(1'b0, 24'h000010, 16'h0000, 1'b0);
      wait_done();
      if (hs_log.size() >= h0 + 2 && rsp_log.size() >= r0 + 1)
         chk_int("b2b_hs_gap", hs_log[h0+1] - rsp_log[r0], 2);
      else
         fail_now("b2b_hs_gap", "missing handshake or response record");
      chk_int("b2b_select_gap", last_gap, 2);

      // reset in the middle of a read
      issue(1'b0, 24'h001234, 16'h0000, 1'b0);
      repeat (39) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(exp_q.pop_back());
      void'(exp_fr_q.pop_back());
      hs_q.delete();
      last_rd = '0;
      chk("abort_select", 48'(spi_select), 48'(1));
      chk("abort_sclk",   48'(spi_clk),    48'(0));
      chk("abort_rspv",   48'(rsp_valid),  48'(0));
      chk("abort_rdata",  48'(rsp_rdata),  48'(0));
      @(posedge clk); #1;
      chk("abort_ready", 48'(req_ready), 48'(1));
      issue(1'b0, 24'h001234, 16'h0000, 1'b0);
      wait_done();

      // address extremes
      issue(1'b0, 24'hFFFFFE, 16'h0000, 1'b0);
      wait_done();
      issue(1'b0, 24'h000000, 16'h0000, 1'b0);
      wait_done();

      // randomized mix over a small window so reads hit earlier writes
      for (int i = 0; i < 20; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 24'h000100 + 24'($urandom_range(0, 15));
         d = 16'($urandom);
         issue(w, a, d, 1'b0);
         if ($urandom_range(0, 1) == 1) wait_done();
      end
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
